// File: rtl/booth_pkg.sv
// Shared constants for the Booth multiplier datapath registers.
package booth_pkg;

    localparam logic [1:0] SH_LSR = 2'b00;
    localparam logic [1:0] SH_ASR = 2'b01;
    localparam logic [1:0] SH_LSL = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/booth_shift_acc_shift_step.sv
// Single-bit shift of a W-bit register in one of four modes.
// Also used by the multiplier Q register.
module shift_step
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  logic [1:0]   mode,
    input  logic         sh_i,
    output logic [W-1:0] q_nxt,
    output logic         bit_o
);

    always_comb begin
        q_nxt = q;
        bit_o = q[0];
        case (mode)
            SH_LSR: q_nxt = {sh_i, q[W-1:1]};
            SH_ASR: q_nxt = {q[W-1], q[W-1:1]};
            SH_LSL: begin
                q_nxt = {q[W-2:0], sh_i};
                bit_o = q[W-1];
            end
            default: q_nxt = {q[0], q[W-1:1]};
        endcase
    end

endmodule

// File: rtl/booth_shift_acc.sv
// Booth accumulator (A register): loads adder sums and runs multi-bit
// shift sequences under a start/busy/done handshake; drives a tri-state bus.
module booth_shift_acc
    import booth_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          ld_sum,
    input  logic [W-1:0]  sum,
    input  logic          sh_start,
    input  logic [CW-1:0] sh_cnt,
    input  logic [1:0]    sh_mode,
    input  logic          sh_i,
    input  logic          ld_obus,
    output logic [W-1:0]  obus,
    output logic [W-1:0]  q,
    output logic          sh_o,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [CW-1:0] rem;
    logic [1:0]    mode_r;
    logic [W-1:0]  q_nxt;
    logic          bit_o;

    shift_step #(.W(W)) u_step (
        .q     (q),
        .mode  (mode_r),
        .sh_i  (sh_i),
        .q_nxt (q_nxt),
        .bit_o (bit_o)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= ST_IDLE;
            rem    <= '0;
            mode_r <= SH_LSR;
            q      <= '0;
            sh_o   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                state <= ST_IDLE;
                rem   <= '0;
                q     <= '0;
                sh_o  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ld_sum) begin
                            q <= sum;
                        end else if (sh_start) begin
                            // A zero count completes at once without entering SHIFT
                            if (sh_cnt != '0) begin
                                rem    <= sh_cnt;
                                mode_r <= sh_mode;
                                state  <= ST_SHIFT;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        q    <= q_nxt;
                        sh_o <= bit_o;
                        rem  <= rem - CW'(1);
                        if (rem == CW'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign obus = ld_obus ? q : 'z;

endmodule
